// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler_if
// Description : Requester/transmitter-side bundle for uart_tx_scheduler.
//               slave  = the scheduler, master = requesters + UART TX side.
// Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int c_ID_W = $clog2(NUM_REQ);

    logic                   en;
    logic [NUM_REQ-1:0]     req;
    logic [8*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]     gnt;
    logic                   tx_start;
    logic [7:0]             tx_data;
    logic                   busy;
    logic                   done;
    logic [c_ID_W-1:0]      done_id;

    modport slave (
        input  en,
        input  req,
        input  req_data,
        output gnt,
        output tx_start,
        output tx_data,
        output busy,
        output done,
        output done_id
    );

    modport master (
        output en,
        output req,
        output req_data,
        input  gnt,
        input  tx_start,
        input  tx_data,
        input  busy,
        input  done,
        input  done_id
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Round-robin sharing of one 8N1 UART transmitter between
//               NUM_REQ byte requesters. Drives the transmitter's strobe and
//               data byte and times every frame from the baud divisor, since
//               the transmitter reports no busy status of its own.
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 10416,
    parameter int FRAME_BITS   = 12
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_scheduler_if.slave bus
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(FRAME_BITS * CLKS_PER_BIT);

    // Strobe is held while the counter runs 0..CLKS_PER_BIT-1 after the
    // grant cycle, so the transmitter sees exactly one baud tick with it high.
    localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(CLKS_PER_BIT);
    // Remaining reserved time after the strobe window; release lands on
    // grant + 1 + FRAME_BITS*CLKS_PER_BIT.
    localparam logic [c_CNT_W-1:0] c_FRAME_LAST = c_CNT_W'((FRAME_BITS - 1) * CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_ID_W-1:0]  c_LAST_ID    = c_ID_W'(NUM_REQ - 1);
    localparam logic [c_ID_W-1:0]  c_ID_ONE     = c_ID_W'(1);
    localparam logic [c_ID_W:0]    c_NREQ_EXT   = (c_ID_W + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_GNT_ONE    = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_FRAME = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_ID_W-1:0]    r_ptr;
    logic [c_ID_W-1:0]    r_cur_id;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_tx_start;
    logic [7:0]           r_tx_data;
    logic                 r_busy;
    logic                 r_done;
    logic [c_ID_W-1:0]    r_done_id;

    logic [7:0]           w_bytes [NUM_REQ];
    logic                 w_found;
    logic [c_ID_W-1:0]    w_pick;
    logic [c_ID_W:0]      w_sum;
    logic [c_ID_W-1:0]    w_next_ptr;

    // Split the flat request data bus into one byte per channel.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign w_bytes[g] = bus.req_data[8*g +: 8];
    end

    // Round-robin search: first set request at or above the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (c_ID_W + 1)'(k);
            if (w_sum >= c_NREQ_EXT) begin
                w_sum = w_sum - c_NREQ_EXT;
            end
            if (!w_found && bus.req[w_sum[c_ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[c_ID_W-1:0];
            end
        end
    end

    // Pointer moves to the channel after the one being granted.
    always_comb begin
        w_next_ptr = (w_pick == c_LAST_ID) ? '0 : (w_pick + c_ID_ONE);
    end

    // Grant / strobe / frame-timing state machine with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_cur_id   <= '0;
            r_gnt      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_done_id  <= '0;
        end else begin
            // gnt and done are single-cycle pulses unless re-asserted below.
            r_gnt  <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.en && w_found) begin
                        r_gnt     <= c_GNT_ONE << w_pick;
                        r_tx_data <= w_bytes[w_pick];
                        r_cur_id  <= w_pick;
                        r_ptr     <= w_next_ptr;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    // Drop the strobe well before the transmitter's 10 shifts
                    // complete so it cannot launch a second frame.
                    if (r_cnt == c_START_LAST) begin
                        r_tx_start <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_FRAME;
                    end else begin
                        r_tx_start <= 1'b1;
                        r_cnt      <= r_cnt + c_CNT_ONE;
                    end
                end
                S_FRAME: begin
                    if (r_cnt == c_FRAME_LAST) begin
                        r_done    <= 1'b1;
                        r_done_id <= r_cur_id;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_busy     <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.tx_start = r_tx_start;
    assign bus.tx_data  = r_tx_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.done_id  = r_done_id;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Directed self-checking bench for uart_tx_scheduler with a
//               behavioural 8N1 transmitter sharing the same baud divisor.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    localparam int NR  = 4;
    localparam int CPB = 4;
    localparam int FB  = 12;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_scheduler_if #(.NUM_REQ(NR)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ      (NR),
        .CLKS_PER_BIT (CPB),
        .FRAME_BITS   (FB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural transmitter: free-running baud tick, starts a frame when
    // tx_start is seen on a tick while idle; records each emitted frame.
    int         bcnt;
    int         bit_n;
    logic       txd;
    logic       tx_act;
    logic [8:0] sh;
    logic [9:0] rec;
    logic [9:0] frame_q [$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt <= 0; bit_n <= 0; txd <= 1'b1; tx_act <= 1'b0; sh <= '0; rec <= '0;
        end else if (bcnt == CPB - 1) begin
            bcnt <= 0;
            if (!tx_act) begin
                if (bus.tx_start) begin
                    sh <= {1'b1, bus.tx_data}; txd <= 1'b0; rec[0] <= 1'b0;
                    bit_n <= 1; tx_act <= 1'b1;
                end
            end else if (bit_n == 10) begin
                txd <= 1'b1; tx_act <= 1'b0; frame_q.push_back(rec);
            end else begin
                txd <= sh[0]; rec[bit_n] <= sh[0]; sh <= sh >> 1; bit_n <= bit_n + 1;
            end
        end else begin
            bcnt <= bcnt + 1;
        end
    end

    task automatic wait_gnt(input int limit, output logic ok, output int id, output int at);
        ok = 1'b0; id = -1; at = 0;
        for (int n = 0; n < limit && !ok; n++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                ok = 1'b1; at = cyc;
                for (int k = 0; k < NR; k++) if (bus.gnt[k]) id = k;
            end
        end
    endtask

    task automatic wait_done(input int limit, output logic ok, output int id, output int at);
        ok = 1'b0; id = -1; at = 0;
        for (int n = 0; n < limit && !ok; n++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1; at = cyc; id = int'(bus.done_id);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; bus.en = 1'b0; bus.req = '0; bus.req_data = '0;
        repeat (3) @(negedge clk);
        total++; if (bus.gnt !== 4'b0)      begin bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        total++; if (bus.busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.done_id !== 2'd0)  begin bad++; $display("FAIL reset_done_id: got %0d want 0", bus.done_id); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0) begin bad++; $display("FAIL idle_after_reset: busy %b gnt %b want 0/0000", bus.busy, bus.gnt); end
    endtask

    task automatic test_single;
        logic ok, dok; int id, g, d, did, starts, first_start; logic [9:0] fr;
        frame_q.delete();
        bus.en = 1'b1; bus.req_data[23:16] = 8'hA5; bus.req = 4'b0100;
        wait_gnt(20, ok, id, g);
        total++; if (!ok || bus.gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
        total++; if (bus.tx_data !== 8'hA5) begin bad++; $display("FAIL single_tx_data: got %h want a5", bus.tx_data); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        bus.req = '0;
        starts = 0; first_start = -1; dok = 1'b0; d = 0; did = -1;
        for (int n = 0; n < 80 && !dok; n++) begin
            @(negedge clk);
            if (n == 0) begin
                total++; if (bus.gnt !== 4'b0) begin bad++; $display("FAIL single_gnt_pulse: got %b want 0000", bus.gnt); end
            end
            if (bus.tx_start === 1'b1) begin
                starts++;
                if (first_start < 0) first_start = cyc - g;
            end
            if (bus.done === 1'b1) begin
                dok = 1'b1; d = cyc; did = int'(bus.done_id);
                total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_at_done: got %b want 0", bus.busy); end
            end
        end
        total++; if (starts != 4)      begin bad++; $display("FAIL single_start_len: got %0d want 4", starts); end
        total++; if (first_start != 1) begin bad++; $display("FAIL single_start_delay: got %0d want 1", first_start); end
        total++; if (!dok || d - g != 49) begin bad++; $display("FAIL single_done_latency: got %0d want 49", d - g); end
        total++; if (did != 2)         begin bad++; $display("FAIL single_done_id: got %0d want 2", did); end
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL single_done_pulse: got %b want 0", bus.done); end
        fr = (frame_q.size() > 0) ? frame_q[0] : 10'h000;
        total++; if (frame_q.size() != 1 || fr !== 10'b1101001010) begin bad++; $display("FAIL single_txd_frame: got %b (n=%0d) want 1101001010", fr, frame_q.size()); end
    endtask

    task automatic test_round_robin;
        logic ok; int id, g, prev, did, d; logic [9:0] fr;
        logic [7:0] exp_b  [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        int         exp_id [5] = '{0, 1, 2, 3, 0};
        logic [9:0] exp_f  [5] = '{10'b1000100000, 10'b1000100010, 10'b1000100100, 10'b1000100110, 10'b1000100000};
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        frame_q.delete();
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10}; bus.req = 4'b1111;
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_gnt(80, ok, id, g);
            total++; if (!ok || id != exp_id[n]) begin bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", n, id, exp_id[n]); end
            total++; if (bus.tx_data !== exp_b[n]) begin bad++; $display("FAIL rr_tx_data[%0d]: got %h want %h", n, bus.tx_data, exp_b[n]); end
            if (n > 0) begin
                total++; if (g - prev != 50) begin bad++; $display("FAIL rr_spacing[%0d]: got %0d want 50", n, g - prev); end
            end
            prev = g;
        end
        bus.req = '0;
        wait_done(80, ok, did, d);
        total++; if (!ok || did != 0) begin bad++; $display("FAIL rr_last_done: got %0d want 0", did); end
        total++; if (frame_q.size() != 5) begin bad++; $display("FAIL rr_frame_count: got %0d want 5", frame_q.size()); end
        for (int k = 0; k < 5 && k < frame_q.size(); k++) begin
            fr = frame_q[k];
            total++; if (fr !== exp_f[k]) begin bad++; $display("FAIL rr_txd_frame[%0d]: got %b want %b", k, fr, exp_f[k]); end
        end
    endtask

    task automatic test_wrap;
        logic ok; int id, g, did, d;
        bus.req = 4'b1000;
        wait_gnt(20, ok, id, g);
        total++; if (!ok || id != 3) begin bad++; $display("FAIL wrap_first: got %0d want 3", id); end
        bus.req = 4'b1001;
        wait_gnt(80, ok, id, g);
        total++; if (!ok || id != 0) begin bad++; $display("FAIL wrap_to_ch0: got %0d want 0", id); end
        bus.req = 4'b1000;
        wait_gnt(80, ok, id, g);
        total++; if (!ok || id != 3) begin bad++; $display("FAIL wrap_then_ch3: got %0d want 3", id); end
        bus.req = '0;
        wait_done(80, ok, did, d);
        total++; if (!ok || did != 3) begin bad++; $display("FAIL wrap_done_id: got %0d want 3", did); end
    endtask

    task automatic test_enable;
        logic ok; int id, g, did, d, gcount;
        bus.req = 4'b0001;
        wait_gnt(20, ok, id, g);
        total++; if (!ok || id != 0) begin bad++; $display("FAIL en_first_gnt: got %0d want 0", id); end
        bus.req = '0;
        repeat (10) @(negedge clk);
        bus.en = 1'b0; bus.req = 4'b0010;
        wait_done(80, ok, did, d);
        total++; if (!ok || did != 0) begin bad++; $display("FAIL en_frame_completes: got %0d want 0", did); end
        gcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.gnt != '0) gcount++;
        end
        total++; if (gcount != 0 || bus.busy !== 1'b0) begin bad++; $display("FAIL en_blocks_grant: got %0d grants busy %b want 0/0", gcount, bus.busy); end
        bus.en = 1'b1;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL en_regrant: got %b want 0010", bus.gnt); end
        bus.req = '0;
        wait_done(80, ok, did, d);
        total++; if (!ok || did != 1) begin bad++; $display("FAIL en_done_id: got %0d want 1", did); end
    endtask

    task automatic test_data_hold;
        logic ok; int id, g, did, d; logic [9:0] fr;
        frame_q.delete();
        bus.req_data[23:16] = 8'h3C; bus.req = 4'b0100;
        wait_gnt(20, ok, id, g);
        total++; if (!ok || id != 2) begin bad++; $display("FAIL hold_gnt: got %0d want 2", id); end
        bus.req = '0;
        repeat (8) @(negedge clk);
        bus.req_data[23:16] = 8'hFF;
        repeat (10) @(negedge clk);
        total++; if (bus.tx_data !== 8'h3C) begin bad++; $display("FAIL hold_tx_data_mid: got %h want 3c", bus.tx_data); end
        wait_done(80, ok, did, d);
        total++; if (!ok || bus.tx_data !== 8'h3C) begin bad++; $display("FAIL hold_tx_data_done: got %h want 3c", bus.tx_data); end
        fr = (frame_q.size() > 0) ? frame_q[0] : 10'h000;
        total++; if (frame_q.size() != 1 || fr !== 10'b1001111000) begin bad++; $display("FAIL hold_txd_frame: got %b (n=%0d) want 1001111000", fr, frame_q.size()); end
    endtask

    task automatic test_reset_midframe;
        logic ok; int id, g, gcount;
        bus.req_data[7:0] = 8'h81; bus.req = 4'b0001;
        wait_gnt(20, ok, id, g);
        bus.req = '0;
        repeat (20) @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %b want 1", bus.busy); end
        #2 reset = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin bad++; $display("FAIL rst_frame_busy_start: got %b/%b want 0/0", bus.busy, bus.tx_start); end
        total++; if (bus.gnt !== 4'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL rst_frame_gnt_done: got %b/%b want 0000/0", bus.gnt, bus.done); end
        total++; if (txd !== 1'b1 || bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_frame_txd_data: got %b/%h want 1/00", txd, bus.tx_data); end
        @(negedge clk);
        reset = 1'b0;
        gcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.gnt != '0 || bus.busy) gcount++;
        end
        total++; if (gcount != 0) begin bad++; $display("FAIL rst_stays_idle: got %0d active cycles want 0", gcount); end
        // Second reset while the strobe is high.
        bus.req = 4'b0001;
        wait_gnt(20, ok, id, g);
        bus.req = '0;
        repeat (2) @(negedge clk);
        total++; if (bus.tx_start !== 1'b1) begin bad++; $display("FAIL rst_pre_start: got %b want 1", bus.tx_start); end
        #2 reset = 1'b1;
        #1;
        total++; if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rst_start_drop: got %b/%b want 0/0", bus.tx_start, bus.busy); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_enable();
        test_data_hold();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one 8N1 UART transmitter between NUM_REQ byte requesters using round-robin arbitration. The transmitter has no busy output, so this block drives its transmit strobe and data byte and times each frame itself from the baud divisor. It sits between the application byte sources and the transmitter, and it is the only driver of the transmitter's transmit and data inputs.

Parameters:
NUM_REQ, 4, number of requester channels (2..8)
CLKS_PER_BIT, 10416, clk cycles per baud tick; must equal the transmitter's divisor count (terminal count + 1)
FRAME_BITS, 12, bit periods reserved per frame from grant to release (10 frame bits + 2 guard); minimum 11

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  1 = new grants allowed; 0 = the frame in flight finishes, then no new grants
req  in  NUM_REQ  per-channel request level; requester holds it until its gnt bit pulses
req_data  in  8*NUM_REQ  channel i byte on bits [8i+7:8i]; stable while req[i]=1
gnt  out  NUM_REQ  one-hot, one-cycle pulse when a channel's byte is accepted
tx_start  out  1  to transmitter transmit input
tx_data  out  8  to transmitter data input
busy  out  1  1 from grant until frame release
done  out  1  one-cycle pulse at frame release
done_id  out  clog2(NUM_REQ)  index of the channel whose frame completed; valid with done

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt=0, tx_start=0, tx_data=8'h00, busy=0, done=0, done_id=0, rr pointer=0, counter=0.
- States: IDLE, START, FRAME.
- IDLE: if en=1 and req!=0, grant the first set req bit searching upward from the rr pointer with wrap (index NUM_REQ-1 wraps to 0).
  - In that cycle: gnt[i] pulses; req_data[i] is latched into tx_data; cur_id=i; rr pointer = (i+1) mod NUM_REQ; busy=1; counter=0.
  - Next state: START.
  - If req==0 or en=0: stay in IDLE, all outputs idle.
- START: tx_start=1 for exactly CLKS_PER_BIT cycles. This guarantees the transmitter sees it on a baud tick while idle.
  - Then tx_start=0 and the state moves to FRAME.
  - The strobe must drop before the transmitter finishes its 10 shifts, so it never retriggers.
- FRAME: count until (FRAME_BITS-1)*CLKS_PER_BIT cycles have elapsed.
  - Then: done pulses for 1 cycle, done_id=cur_id, busy=0, state=IDLE.
- Grant-to-release is exactly 1 + FRAME_BITS*CLKS_PER_BIT cycles.
- Earliest next grant is the cycle after done (an IDLE cycle). No back-to-back grant in the done cycle.
- tx_data holds the latched byte from grant until the next grant. It is not affected by req_data changes mid-frame.
- Counter width: clog2(FRAME_BITS*CLKS_PER_BIT) bits. Single counter, reset on each state entry. No wrap occurs inside a state.
- en deasserted during START or FRAME: no effect on the frame in flight. It only blocks the next grant.
- A req bit dropped before grant is simply not considered. Dropping req after gnt has no effect.
- Single requester repeatedly: served every frame; rr pointer still advances.
- All requesters set: grant order follows the rr pointer, e.g. 0,1,2,3,0...
- Reset asserted mid-frame: all outputs go to reset values immediately. The transmitter is reset by the same reset net.

Test Plan:
- Reset, then req=4'b0100 with byte 8'hA5 on channel 2, CLKS_PER_BIT=4, FRAME_BITS=12 -> gnt=4'b0100 for 1 cycle; tx_data=8'hA5; tx_start high exactly 4 cycles; done pulses 49 cycles after the grant cycle with done_id=2; transmitter TxD shows 0,1,0,1,0,0,1,0,1,1.
- req=4'b1111 held with bytes 8'h10/8'h11/8'h12/8'h13 -> grants in order ch0,ch1,ch2,ch3,ch0; consecutive grants 50 cycles apart; each TxD frame carries the matching byte.
- After serving ch3, assert req=4'b1001 -> ch0 is granted next (wrap), then ch3.
- en=0 asserted 10 cycles into a frame with req=4'b0010 pending -> the current frame completes and done pulses; no gnt while en=0; ch1 is granted 1 cycle after en returns to 1.
- Assert reset asynchronously mid-FRAME -> busy, tx_start, gnt and done go to 0 immediately; TxD=1; after release with req=0 the block stays in IDLE.
- req_data for the granted channel changed to 8'hFF mid-frame -> tx_data and TxD still carry the originally latched byte.
